data_debounce: RTL and testbench
================================

# data_debounce

Per-bit glitch filter and edge detector placed directly downstream of `data_sync`, consuming its already-synchronized `data_o` bus. Each bit's output changes only after the input has held a new value for `STABLE_CNT` consecutive clock cycles. The block then emits one-cycle rise/fall pulses for consumers such as button, switch and strap-pin logic.

## Interface
- `D_WIDTH`, default 8: number of independent bits filtered.
- `STABLE_CNT`, default 1000: consecutive differing samples required before a bit's output updates; legal range 1 to 2^20.
- `INIT_VAL`, default `'0`: reset value of `data_o` (`D_WIDTH` bits).
- `clk_i`, input, 1: sole clock; all state updates on its rising edge.
- `rst_i`, input, 1: reset, asynchronous and active-high.
- `data_i`, input, `D_WIDTH`: synchronized input bus (from `data_sync.data_o`); never fed asynchronous signals directly.
- `data_o`, output, `D_WIDTH`: debounced, registered value.
- `rise_o`, output, `D_WIDTH`: one-cycle pulse when `data_o[k]` goes 0->1.
- `fall_o`, output, `D_WIDTH`: one-cycle pulse when `data_o[k]` goes 1->0.

## Operation
- Bits are fully independent. Each bit has a counter `cnt[k]`, `$clog2(STABLE_CNT+1)` bits wide, and a 2-state FSM:
  - `ST_STABLE`: `cnt` = 0 and `data_i[k]` == `data_o[k]`.
  - `ST_PENDING`: a mismatch is being counted.
- Each rising edge, per bit:
  - Match (`data_i[k]` == `data_o[k]`): `cnt` <= 0; go to `ST_STABLE`. Any partial count is discarded.
  - Mismatch with `cnt` == `STABLE_CNT`-1: `data_o[k]` <= `data_i[k]`; `cnt` <= 0; go to `ST_STABLE`; pulse `rise_o[k]` or `fall_o[k]` according to the new value.
  - Other mismatch: `cnt` <= `cnt`+1; go to `ST_PENDING`.
- Counters saturate by construction: the count never exceeds `STABLE_CNT`-1, so there is no wrap-around.
- A glitch shorter than `STABLE_CNT` cycles never reaches `data_o`.
- Toggling that returns to the current `data_o` value before the count completes restarts the count from 0 on the next mismatch.
- `STABLE_CNT`=1: `data_o` follows `data_i` with exactly one cycle delay, and every change pulses.
- `rise_o[k]` and `fall_o[k]` are never high together and never high on consecutive cycles for the same bit when `STABLE_CNT` >= 2.

## Timing
- Reset values: `data_o` = `INIT_VAL`, `rise_o` = 0, `fall_o` = 0, all `cnt` = 0, all FSMs `ST_STABLE`.
- Reset is asynchronous. Assertion mid-count clears that count immediately, and no pulse is emitted.
- Latency: suppose `data_i[k]` changes and first differs from `data_o[k]` at sampling edge N, and holds. Then `data_o[k]` and the edge pulse appear after edge N+`STABLE_CNT`-1.
- Pulses are registered in the same edge as the `data_o` update and last exactly one cycle.
- After deassertion, the first sampled edge is processed normally. If `data_i` differs from `INIT_VAL` at that point, it is debounced like any other change; no pulse is produced on reset exit itself.

## Configuration
- `DATA_DEBOUNCE_EDGE_EN` defined: `rise_o`/`fall_o` are generated as described above.
- `DATA_DEBOUNCE_EDGE_EN` undefined:
  - Pulse logic is removed.
  - `rise_o` and `fall_o` remain as ports and are tied to 0.
  - `data_o` behaviour is unchanged.

## Structure
- Package `data_debounce_pkg` holds:
  - typedef enum logic `{ST_STABLE, ST_PENDING}` `deb_state_t`;
  - the counter-width function `cnt_width(stable_cnt)`.
- Sub-module `data_debounce_bit`:
  - one bit's counter, FSM, output register and edge pulses;
  - instantiated `D_WIDTH` times via generate.
- Top level contains only parameter checks (elaboration error if `STABLE_CNT` < 1) and the generate loop.

## Test plan
- Reset check: `INIT_VAL`=8'hA5, assert `rst_i` asynchronously between edges -> `data_o`=8'hA5 immediately; `rise_o`=`fall_o`=0.
- Clean change: `STABLE_CNT`=4, bit 0 driven 0->1 and held -> `data_o[0]`=1 after the 4th sampling edge; `rise_o[0]` high for exactly that one cycle; other bits unchanged.
- Glitch rejection: `STABLE_CNT`=4, bit 3 pulsed high for 3 cycles then low -> `data_o[3]` stays 0 and no pulses. Repeating 3-high/1-low bursts for 100 cycles -> still no change.
- Independent bits: `STABLE_CNT`=4, bit 1 rises at cycle 0 and bit 2 falls at cycle 2 (`INIT_VAL` bit 2 = 1) -> `rise_o[1]` at cycle 3, `fall_o[2]` at cycle 5.
- Reset mid-count: `STABLE_CNT`=10, hold bit 0 high for 6 cycles, pulse `rst_i`, keep bit 0 high -> `data_o[0]` updates 10 edges after reset release, not 4.
- Macro off: `DATA_DEBOUNCE_EDGE_EN` undefined, repeat the clean-change test -> identical `data_o` timing; `rise_o`/`fall_o` constantly 0.

Source files
------------

// File: rtl/data_debounce_pkg.sv
// Shared types and helpers for the per-bit debounce filter.
package data_debounce_pkg;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } deb_state_t;

    localparam int MAX_STABLE_CNT = 1 << 20;

    // Counter must hold values up to stable_cnt-1; one extra bit of headroom keeps width >= 1.
    function automatic int cnt_width(input int stable_cnt);
        return $clog2(stable_cnt + 1);
    endfunction

endpackage

// File: rtl/data_debounce_bit.sv
// One bit of the debounce filter: mismatch counter, 2-state FSM, output register, edge pulses.
// Edge pulses are generated only when DATA_DEBOUNCE_EDGE_EN is defined; otherwise rise/fall are tied low.
module data_debounce_bit
    import data_debounce_pkg::*;
#(
    parameter int   STABLE_CNT = 1000,
    parameter logic INIT_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int             CW   = cnt_width(STABLE_CNT);
    localparam logic [CW-1:0]  LAST = CW'(STABLE_CNT - 1);

    deb_state_t    state;
    deb_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          q_nxt;
    logic          mismatch;
    logic          update;

    assign mismatch = (din != dout);
    assign update   = mismatch && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_STABLE;
            cnt   <= '0;
            dout  <= INIT_VAL;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dout  <= q_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_STABLE;
        if (mismatch && !update) begin
            state_nxt = ST_PENDING;
        end
    end

    // ST_STABLE implies cnt == 0, so the first mismatch always loads 1.
    always_comb begin
        cnt_nxt = '0;
        q_nxt   = dout;
        if (update) begin
            q_nxt = din;
        end else if (mismatch) begin
            cnt_nxt = (state == ST_PENDING) ? cnt + CW'(1) : CW'(1);
        end
    end

`ifdef DATA_DEBOUNCE_EDGE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= update && din;
            fall <= update && !din;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/data_debounce.sv
// Per-bit glitch filter with rise/fall pulses, fed from the synchronizer's output bus.
// Edge pulses exist only when DATA_DEBOUNCE_EDGE_EN is defined.
module data_debounce
    import data_debounce_pkg::*;
#(
    parameter int                 D_WIDTH    = 8,
    parameter int                 STABLE_CNT = 1000,
    parameter logic [D_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [D_WIDTH-1:0] data_i,
    output logic [D_WIDTH-1:0] data_o,
    output logic [D_WIDTH-1:0] rise_o,
    output logic [D_WIDTH-1:0] fall_o
);

    if (STABLE_CNT < 1) begin : gen_bad_cnt_low
        $error("data_debounce: STABLE_CNT must be at least 1");
    end
    if (STABLE_CNT > MAX_STABLE_CNT) begin : gen_bad_cnt_high
        $error("data_debounce: STABLE_CNT must not exceed 2^20");
    end

    for (genvar k = 0; k < D_WIDTH; k++) begin : gen_bit
        data_debounce_bit #(
            .STABLE_CNT(STABLE_CNT),
            .INIT_VAL  (INIT_VAL[k])
        ) u_bit (
            .clk (clk_i),
            .rst (rst_i),
            .din (data_i[k]),
            .dout(data_o[k]),
            .rise(rise_o[k]),
            .fall(fall_o[k])
        );
    end

endmodule

// File: tb/tb_data_debounce.sv
// Directed bench for data_debounce: several instances with different STABLE_CNT/INIT_VAL.
module tb_data_debounce;

`ifdef DATA_DEBOUNCE_EDGE_EN
    localparam logic [7:0] EM = 8'hFF;
`else
    localparam logic [7:0] EM = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst_a, rst_b, rst_c, rst_d;
    logic [7:0] data_a, data_b, data_c, data_d;
    logic [7:0] q_a, q_b, q_c, q_d;
    logic [7:0] r_a, r_b, r_c, r_d;
    logic [7:0] f_a, f_b, f_c, f_d;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_debounce #(.D_WIDTH(8), .STABLE_CNT(2), .INIT_VAL(8'hA5)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .data_i(data_a), .data_o(q_a), .rise_o(r_a), .fall_o(f_a));
    data_debounce #(.D_WIDTH(8), .STABLE_CNT(4), .INIT_VAL(8'h04)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .data_i(data_b), .data_o(q_b), .rise_o(r_b), .fall_o(f_b));
    data_debounce #(.D_WIDTH(8), .STABLE_CNT(10), .INIT_VAL(8'h00)) dut_c (
        .clk_i(clk), .rst_i(rst_c), .data_i(data_c), .data_o(q_c), .rise_o(r_c), .fall_o(f_c));
    data_debounce #(.D_WIDTH(8), .STABLE_CNT(1), .INIT_VAL(8'h00)) dut_d (
        .clk_i(clk), .rst_i(rst_d), .data_i(data_d), .data_o(q_d), .rise_o(r_d), .fall_o(f_d));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] prev;
        logic [7:0] vals [6];
        vals = '{8'h3C, 8'h3C, 8'hC3, 8'hFF, 8'h00, 8'h81};

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
        data_a = 8'hA5; data_b = 8'h04; data_c = 8'h00; data_d = 8'h00;
        #1;
        check("reset_q_a", q_a, 8'hA5);
        check("reset_rise_a", r_a, 8'h00);
        check("reset_fall_a", f_a, 8'h00);
        check("reset_q_b", q_b, 8'h04);
        #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;

        // dut_a (STABLE_CNT=2): change to 5A, then async reset back to A5
        tick();
        data_a = 8'h5A;
        tick();
        check("a_hold_q", q_a, 8'hA5);
        tick();
        check("a_upd_q", q_a, 8'h5A);
        check("a_upd_rise", r_a, 8'h5A & EM);
        check("a_upd_fall", f_a, 8'hA5 & EM);
        tick();
        check("a_after_rise", r_a, 8'h00);
        check("a_after_fall", f_a, 8'h00);
        #2 rst_a = 1'b1;
        #1;
        check("a_async_rst_q", q_a, 8'hA5);
        check("a_async_rst_rise", r_a, 8'h00);
        check("a_async_rst_fall", f_a, 8'h00);
        #1 rst_a = 1'b0;
        tick();
        check("a_exit_q", q_a, 8'hA5);
        check("a_exit_rise", r_a, 8'h00);
        tick();
        check("a_exit_upd_q", q_a, 8'h5A);

        // dut_b (STABLE_CNT=4): clean rise on bit 0
        data_b = 8'h05;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("b_clean_wait_q", q_b, 8'h04);
            check("b_clean_wait_rise", r_b, 8'h00);
        end
        tick();
        check("b_clean_q", q_b, 8'h05);
        check("b_clean_rise", r_b, 8'h01 & EM);
        check("b_clean_fall", f_b, 8'h00);
        tick();
        check("b_clean_rise_end", r_b, 8'h00);

        // independent bits: bit1 rises at cycle 0, bit2 falls at cycle 2
        data_b = 8'h07;
        tick();
        tick();
        data_b = 8'h03;
        tick();
        check("b_ind_c2_q", q_b, 8'h05);
        tick();
        check("b_ind_c3_q", q_b, 8'h07);
        check("b_ind_c3_rise", r_b, 8'h02 & EM);
        check("b_ind_c3_fall", f_b, 8'h00);
        tick();
        check("b_ind_c4_rise", r_b, 8'h00);
        check("b_ind_c4_fall", f_b, 8'h00);
        tick();
        check("b_ind_c5_q", q_b, 8'h03);
        check("b_ind_c5_fall", f_b, 8'h04 & EM);
        check("b_ind_c5_rise", r_b, 8'h00);
        tick();
        check("b_ind_c6_fall", f_b, 8'h00);

        // glitch rejection on bit 3: 25 bursts of 3 high / 1 low
        for (int b = 0; b < 25; b++) begin
            for (int c = 0; c < 4; c++) begin
                data_b = (c < 3) ? 8'h0B : 8'h03;
                tick();
                check("b_glitch_q", q_b, 8'h03);
                check("b_glitch_pulse", r_b | f_b, 8'h00);
            end
        end

        // dut_c (STABLE_CNT=10): reset mid-count restarts the full count
        data_c = 8'h01;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("c_pre_rst_q", q_c, 8'h00);
        end
        #2 rst_c = 1'b1;
        #1;
        check("c_rst_q", q_c, 8'h00);
        check("c_rst_rise", r_c, 8'h00);
        #1 rst_c = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("c_post_rst_q", q_c, (i == 10) ? 8'h01 : 8'h00);
            check("c_post_rst_rise", r_c, (i == 10) ? (8'h01 & EM) : 8'h00);
        end

        // dut_d (STABLE_CNT=1): one-cycle follow, every change pulses
        prev = 8'h00;
        for (int i = 0; i < 6; i++) begin
            data_d = vals[i];
            tick();
            check("d_follow_q", q_d, vals[i]);
            check("d_follow_rise", r_d, vals[i] & ~prev & EM);
            check("d_follow_fall", f_d, prev & ~vals[i] & EM);
            prev = vals[i];
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
